// File: rtl/npc_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pc_unit_pkg
// Description : Shared definitions for the fetch-side PC unit: next-PC
//               operation encodings and default address-map constants.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pc_unit_pkg;

  // Next-PC operation selected by the D-stage instruction
  typedef enum logic [1:0] {
    NPC_OP_PC4    = 2'd0,
    NPC_OP_BRANCH = 2'd1,
    NPC_OP_JIMM   = 2'd2,
    NPC_OP_JREG   = 2'd3
  } npc_op_e;

  // Default address map (32-bit values, narrowed/widened by the top)
  localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PKG_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PKG_TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] PKG_TEXT_HI  = 32'h0000_6FFC;

endpackage : npc_pc_unit_pkg
`default_nettype wire

// File: rtl/npc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : npc_target_calc
// Description : Combinational redirect-target arithmetic for the D stage.
//   pc_d_i       in  D-stage instruction address
//   instr_idx_i  in  instruction bits [25:0] (j index / branch offset)
//   rs_val_i     in  forwarded rs value
//   br_tgt_o     out pc_d + 4 + (sext(offset) << 2)
//   j_tgt_o      out {pc_d[ADDR_W-1:28], index, 2'b00}
//   jr_tgt_o     out rs value
//   pc8_o        out pc_d + 8 (link value)
// Revision    : 1.0 - initial release
// ============================================================================
module npc_target_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_d_i,
  input  logic [25:0]       instr_idx_i,
  input  logic [ADDR_W-1:0] rs_val_i,
  output logic [ADDR_W-1:0] br_tgt_o,
  output logic [ADDR_W-1:0] j_tgt_o,
  output logic [ADDR_W-1:0] jr_tgt_o,
  output logic [ADDR_W-1:0] pc8_o
);

  logic [ADDR_W-1:0] w_br_off;

  // Word offset, sign-extended to the full datapath; all sums wrap silently
  assign w_br_off = {{(ADDR_W-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
  assign br_tgt_o = pc_d_i + ADDR_W'(4) + w_br_off;
  assign pc8_o    = pc_d_i + ADDR_W'(8);
  assign jr_tgt_o = rs_val_i;

  // With a 28-bit datapath there is no region field to carry over
  generate
    if (ADDR_W > 28) begin : g_j_region
      assign j_tgt_o = {pc_d_i[ADDR_W-1:28], instr_idx_i, 2'b00};
    end else begin : g_j_flat
      assign j_tgt_o = {instr_idx_i, 2'b00};
    end
  endgenerate

endmodule : npc_target_calc
`default_nettype wire

// File: rtl/npc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : npc_pc_unit
// Description : Fetch-stage program counter with next-PC selection,
//               exception/eret redirection and illegal-fetch capture.
//   clk, reset    clock, asynchronous active-high reset
//   stall         hold pc_F
//   instr_D, pc_D D-stage instruction and address
//   npc_op_D      PC4 / BRANCH / JIMM / JREG
//   br_taken_D    branch condition result
//   rs_val_D      jr target
//   exc_req       enter exception vector
//   eret_req      return to epc
//   pc_F          current fetch address
//   pc8_D         link value pc_D + 8
//   fetch_exc_F   pc_F misaligned or outside the text window
//   bad_pc(_valid) first faulting fetch address, held until exc_req
// Revision    : 1.0 - initial release
// ============================================================================
module npc_pc_unit
  import npc_pc_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PKG_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(PKG_EXC_VEC),
  parameter logic [ADDR_W-1:0] TEXT_LO  = ADDR_W'(PKG_TEXT_LO),
  parameter logic [ADDR_W-1:0] TEXT_HI  = ADDR_W'(PKG_TEXT_HI)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       instr_D,
  input  logic [ADDR_W-1:0] pc_D,
  input  logic [1:0]        npc_op_D,
  input  logic              br_taken_D,
  input  logic [ADDR_W-1:0] rs_val_D,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_F,
  output logic [ADDR_W-1:0] pc8_D,
  output logic              fetch_exc_F,
  output logic [ADDR_W-1:0] bad_pc,
  output logic              bad_pc_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bad_pc_q, bad_pc_d;
  logic              bad_vld_q, bad_vld_d;
  logic [ADDR_W-1:0] br_tgt, j_tgt, jr_tgt;
  npc_op_e           op;
  logic              unused_instr_hi;

  assign op              = npc_op_e'(npc_op_D);
  assign unused_instr_hi = ^instr_D[31:26];

  npc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_tgt (
    .pc_d_i      (pc_D),
    .instr_idx_i (instr_D[25:0]),
    .rs_val_i    (rs_val_D),
    .br_tgt_o    (br_tgt),
    .j_tgt_o     (j_tgt),
    .jr_tgt_o    (jr_tgt),
    .pc8_o       (pc8_D)
  );

  // Wrapped or out-of-window addresses are followed, then flagged here
  assign fetch_exc_F = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  // Next-PC priority: exception, eret, stall, then D-stage redirect
  always_comb begin
    pc_d = pc_q + ADDR_W'(4);
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      unique case (op)
        NPC_OP_BRANCH: if (br_taken_D) pc_d = br_tgt;
        NPC_OP_JIMM:   pc_d = j_tgt;
        NPC_OP_JREG:   pc_d = jr_tgt;
        default:       pc_d = pc_q + ADDR_W'(4);
      endcase
    end
  end

  // Keep only the first fault; consuming it (exc_req) beats a new capture
  always_comb begin
    bad_pc_d  = bad_pc_q;
    bad_vld_d = bad_vld_q;
    if (exc_req) begin
      bad_vld_d = 1'b0;
    end else if (fetch_exc_F && !stall && !bad_vld_q) begin
      bad_pc_d  = pc_q;
      bad_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      bad_pc_q  <= '0;
      bad_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      bad_pc_q  <= bad_pc_d;
      bad_vld_q <= bad_vld_d;
    end
  end

  assign pc_F         = pc_q;
  assign bad_pc       = bad_pc_q;
  assign bad_pc_valid = bad_vld_q;

endmodule : npc_pc_unit
`default_nettype wire
